// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side handshake and redirect bundle for the PC generator.
interface pc_gen_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             enable_i;
    logic             fetch_ready_i;
    logic             branch_taken_i;
    logic [XLEN-1:0]  branch_target_i;
    logic             trap_i;
    logic [XLEN-1:0]  trap_vector_i;
    logic [XLEN-1:0]  pc_o;
    logic             pc_valid_o;
    logic             misaligned_o;
    logic [CNT_W-1:0] fetch_count_o;
    modport master (
        output enable_i, fetch_ready_i, branch_taken_i, branch_target_i, trap_i, trap_vector_i,
        input  pc_o, pc_valid_o, misaligned_o, fetch_count_o
    );
    modport slave (
        input  enable_i, fetch_ready_i, branch_taken_i, branch_target_i, trap_i, trap_vector_i,
        output pc_o, pc_valid_o, misaligned_o, fetch_count_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter generator with fetch handshake, branch/trap redirect and misaligned-target fault.
module pc_gen #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              CNT_W        = 32
) (
    input  logic     clk_in,
    input  logic     rst_in,
    pc_gen_if.slave  p
);
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);
    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;
    always_comb begin
        xfer    = state_q == RUN && p.fetch_ready_i;
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q + CNT_W'(xfer);
        if (state_q == IDLE) begin
            state_d = p.enable_i ? RUN : IDLE;
        end else if (p.trap_i) begin
            pc_d    = p.trap_vector_i & ~LOW_MASK;
            mis_d   = 1'b0;
            state_d = RUN;
        end else if (state_q == RUN && p.branch_taken_i) begin
            pc_d    = p.branch_target_i;
            // a target off instruction alignment parks the PC until a trap redirects it
            mis_d   = (p.branch_target_i & LOW_MASK) != '0;
            state_d = mis_d ? FAULT : RUN;
        end else if (xfer) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
        valid_d = state_d == RUN;
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end
    assign p.pc_o          = pc_q;
    assign p.pc_valid_o    = valid_q;
    assign p.misaligned_o  = mis_q;
    assign p.fetch_count_o = cnt_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen, 64-bit/4-byte instance with a per-cycle model plus a 32-bit/2-byte instance.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asserts = 0;
    int   n_fail = 0;
    pc_gen_if #(.XLEN(64), .CNT_W(32)) a ();
    pc_gen_if #(.XLEN(32), .CNT_W(4))  b ();
    pc_gen #(.XLEN(64), .RESET_VECTOR(64'h0), .INSTR_BYTES(4), .CNT_W(32)) dut_a (.clk_in(clk), .rst_in(rst), .p(a));
    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .INSTR_BYTES(2), .CNT_W(4))  dut_b (.clk_in(clk), .rst_in(rst), .p(b));
    always #5 clk = ~clk;
    int          m_state;
    logic [63:0] m_pc;
    logic        m_mis;
    logic [31:0] m_cnt;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_state = 0;
        m_pc    = 64'h0;
        m_mis   = 1'b0;
        m_cnt   = 32'h0;
    endtask
    // one clock for both DUTs; dut_a is checked against the reference model every cycle
    task automatic tick();
        logic xf;
        xf = m_state == 1 && a.fetch_ready_i;
        if (m_state == 0) begin
            if (a.enable_i) m_state = 1;
        end else if (a.trap_i) begin
            m_pc = a.trap_vector_i & ~64'h3;
            m_mis = 1'b0;
            m_state = 1;
        end else if (m_state == 1 && a.branch_taken_i) begin
            m_pc = a.branch_target_i;
            if (a.branch_target_i[1:0] != 2'b00) begin
                m_mis = 1'b1;
                m_state = 2;
            end
        end else if (xf) begin
            m_pc = m_pc + 64'd4;
        end
        if (xf) m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        @(negedge clk);
        chk("cyc_pc", a.pc_o, m_pc);
        chk("cyc_valid", 64'(a.pc_valid_o), 64'(m_state == 1));
        chk("cyc_mis", 64'(a.misaligned_o), 64'(m_mis));
        chk("cyc_cnt", 64'(a.fetch_count_o), 64'(m_cnt));
    endtask
    initial begin
        {a.enable_i, a.fetch_ready_i, a.branch_taken_i, a.trap_i} = '0;
        a.branch_target_i = '0;
        a.trap_vector_i = '0;
        {b.enable_i, b.fetch_ready_i, b.branch_taken_i, b.trap_i} = '0;
        b.branch_target_i = '0;
        b.trap_vector_i = '0;
        model_reset();
        #2;
        chk("rst_pc", a.pc_o, 64'h0);
        chk("rst_valid", 64'(a.pc_valid_o), 64'h0);
        chk("rst_mis", 64'(a.misaligned_o), 64'h0);
        chk("rst_cnt", 64'(a.fetch_count_o), 64'h0);
        chk("rst_b_pc", 64'(b.pc_o), 64'h0);
        chk("rst_b_cnt", 64'(b.fetch_count_o), 64'h0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_no_enable", 64'(a.pc_valid_o), 64'h0);
        a.enable_i = 1'b1;
        a.fetch_ready_i = 1'b1;
        tick();
        chk("run_pc0", a.pc_o, 64'h0);
        chk("run_valid", 64'(a.pc_valid_o), 64'h1);
        a.enable_i = 1'b0;
        tick();
        chk("seq_4", a.pc_o, 64'h4);
        tick();
        chk("seq_8", a.pc_o, 64'h8);
        tick();
        chk("seq_c", a.pc_o, 64'hC);
        tick();
        chk("seq_10", a.pc_o, 64'h10);
        chk("seq_cnt4", 64'(a.fetch_count_o), 64'h4);
        a.branch_taken_i = 1'b1;
        a.branch_target_i = 64'h500;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_pc", a.pc_o, 64'h0);
        chk("async_rst_valid", 64'(a.pc_valid_o), 64'h0);
        chk("async_rst_cnt", 64'(a.fetch_count_o), 64'h0);
        rst = 1'b0;
        model_reset();
        a.trap_i = 1'b1;
        a.trap_vector_i = 64'h700;
        tick();
        chk("post_rst_pc", a.pc_o, 64'h0);
        chk("post_rst_idle", 64'(a.pc_valid_o), 64'h0);
        tick();
        chk("idle_ignores_redirect", a.pc_o, 64'h0);
        {a.branch_taken_i, a.trap_i} = '0;
        a.enable_i = 1'b1;
        tick();
        a.enable_i = 1'b0;
        tick();
        tick();
        chk("pre_stall_pc", a.pc_o, 64'h8);
        a.fetch_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", a.pc_o, 64'h8);
            chk("stall_valid", 64'(a.pc_valid_o), 64'h1);
            chk("stall_cnt", 64'(a.fetch_count_o), 64'h2);
        end
        a.branch_taken_i = 1'b1;
        a.branch_target_i = 64'h100;
        a.trap_i = 1'b1;
        a.trap_vector_i = 64'h203;
        tick();
        chk("trap_over_branch_pc", a.pc_o, 64'h200);
        chk("trap_over_branch_mis", 64'(a.misaligned_o), 64'h0);
        a.trap_i = 1'b0;
        a.branch_target_i = 64'h40;
        a.fetch_ready_i = 1'b1;
        tick();
        chk("branch_xfer_pc", a.pc_o, 64'h40);
        chk("branch_xfer_cnt", 64'(a.fetch_count_o), 64'h3);
        a.branch_target_i = 64'h80;
        a.fetch_ready_i = 1'b0;
        tick();
        chk("branch_stall_pc", a.pc_o, 64'h80);
        chk("branch_stall_cnt", 64'(a.fetch_count_o), 64'h3);
        a.branch_target_i = 64'h102;
        a.fetch_ready_i = 1'b1;
        tick();
        chk("fault_pc", a.pc_o, 64'h102);
        chk("fault_mis", 64'(a.misaligned_o), 64'h1);
        chk("fault_valid", 64'(a.pc_valid_o), 64'h0);
        chk("fault_cnt", 64'(a.fetch_count_o), 64'h4);
        a.branch_target_i = 64'h300;
        tick();
        tick();
        chk("fault_hold_pc", a.pc_o, 64'h102);
        a.branch_taken_i = 1'b0;
        a.trap_i = 1'b1;
        a.trap_vector_i = 64'h80;
        tick();
        chk("trap_exit_pc", a.pc_o, 64'h80);
        chk("trap_exit_mis", 64'(a.misaligned_o), 64'h0);
        chk("trap_exit_valid", 64'(a.pc_valid_o), 64'h1);
        chk("trap_exit_cnt", 64'(a.fetch_count_o), 64'h4);
        a.trap_i = 1'b0;
        tick();
        chk("after_trap_seq", a.pc_o, 64'h84);
        a.branch_taken_i = 1'b1;
        a.branch_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
        a.fetch_ready_i = 1'b0;
        tick();
        a.branch_taken_i = 1'b0;
        a.fetch_ready_i = 1'b1;
        tick();
        chk("wrap64_pc", a.pc_o, 64'h0);
        a.fetch_ready_i = 1'b0;
        b.enable_i = 1'b1;
        tick();
        chk("b_run_valid", 64'(b.pc_valid_o), 64'h1);
        b.enable_i = 1'b0;
        b.branch_taken_i = 1'b1;
        b.branch_target_i = 32'hFFFF_FFFE;
        tick();
        chk("b_pre_wrap", 64'(b.pc_o), 64'hFFFF_FFFE);
        b.branch_taken_i = 1'b0;
        b.fetch_ready_i = 1'b1;
        tick();
        chk("b_wrap_pc", 64'(b.pc_o), 64'h0);
        chk("b_cnt1", 64'(b.fetch_count_o), 64'h1);
        for (int i = 0; i < 15; i++) tick();
        chk("b_cnt_wrap", 64'(b.fetch_count_o), 64'h0);
        chk("b_pc_after16", 64'(b.pc_o), 64'h1E);
        b.fetch_ready_i = 1'b0;
        b.branch_taken_i = 1'b1;
        b.branch_target_i = 32'h3;
        tick();
        chk("b_odd_fault_mis", 64'(b.misaligned_o), 64'h1);
        chk("b_odd_fault_valid", 64'(b.pc_valid_o), 64'h0);
        chk("b_odd_fault_pc", 64'(b.pc_o), 64'h3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
